rv32i_dmem_responder: RTL and testbench
=======================================

// Module: rv32i_dmem_responder
// PURPOSE
//  Responder end of the RV32i data-memory interface: accepts address, write data and
//  byte-lane enables from the pipeline MEM stage and returns read data in the same cycle.
//  Holds a byte-writable RAM plus, optionally, a small MMIO block: 64-bit cycle counter,
//  timer compare and tohost/halt.
//  Sits beside the datapath at top level; dmem_we_i comes from the control path.
// PARAMETERS
//  ADDR_WIDTH   10  word-address bits of RAM; 2**ADDR_WIDTH 32-bit words
// PORTS
//  clk_i        in   1   clock, all state updates on rising edge
//  resetn_i     in   1   asynchronous active-low reset
//  dmem_add_i   in   32  byte address (already registered by the MEM stage)
//  dmem_di_i    in   32  write data, already lane-shifted by the initiator
//  dmem_ble_i   in   4   byte-lane enables; bit n = byte n (bits 8n+7:8n)
//  dmem_we_i    in   1   1 = store, 0 = load or idle
//  dmem_do_o    out  32  read data, full word, unshifted
//  timer_irq_o  out  1   cycle counter >= timecmp (registered)
//  halt_o       out  1   sticky; set by a write to TOHOST
//  tohost_o     out  32  last value written to TOHOST
// BEHAVIOUR
//  - Region select: mmio_sel = dmem_add_i[31] (macro on); RAM otherwise.
//    RAM index = dmem_add_i[ADDR_WIDTH+1:2]; address bits [1:0] are ignored.
//  - Read: combinational, zero latency. dmem_do_o = word at the current address, regardless of ble.
//  - Write: on posedge when dmem_we_i=1, only lanes with ble=1 update; ble=0000 writes nothing.
//  - Same-cycle write + read of one address: dmem_do_o shows old data;
//    new data is visible from the next cycle.
//  - RAM contents are not reset. All MMIO state resets: cycle=0, timecmp=64'hFFFF_FFFF_FFFF_FFFF,
//    shadow_hi=0, tohost=0, halt_o=0, timer_irq_o=0.
//  - Reset mid-store: the store is dropped and RAM is unchanged.
//  - MMIO map (offsets from 0x8000_0000):
//      0x00 CYCLE_LO RO; read also latches cycle[63:32] into shadow_hi at that posedge
//      0x04 CYCLE_HI RO; returns shadow_hi
//      0x08 TIMECMP_LO RW; 0x0C TIMECMP_HI RW; byte-lane writes honoured
//      0x10 TOHOST RW; any write with ble!=0 sets halt_o=1 next cycle, tohost_o gets lane-merged data
//      other offsets: read 0, writes ignored; writes to RO registers ignored
//  - "Read" of CYCLE_LO means address selected with dmem_we_i=0; the latch fires every cycle the
//    address is held (idempotent only if the counter has not carried).
//  - cycle counter: +1 every cycle out of reset, wraps 2^64-1 -> 0.
//  - timer_irq_o <= (cycle >= timecmp), unsigned 64-bit compare, so it is 1 cycle late.
//    A timecmp write takes effect in the compare on the following cycle.
//  - halt_o: sticky until reset; the cycle counter keeps running after halt.
// CONFIGURATION
//  RV32I_DMEM_MMIO_EN defined: MMIO block, timer and tohost logic present as above.
//  Not defined: no MMIO decode. Every address maps to RAM (bit 31 ignored, aliasing allowed).
//    timer_irq_o, halt_o and tohost_o are tied to 0.
// TESTING
//  1 SW 0x1234_5678 @0x10 ble=1111, then LW @0x10 -> dmem_do_o=0x1234_5678
//  2 SB 0x0000_AB00 @0x11 ble=0010 over 0x1234_5678 -> read 0x1234_AB78; ble=0000 -> unchanged
//  3 Same cycle: write 0xDEAD_BEEF @0x20 and read @0x20 -> old value; next cycle -> 0xDEAD_BEEF
//  4 Reset, write TIMECMP_LO=20 and TIMECMP_HI=0 -> timer_irq_o rises the cycle after cycle==20;
//    read CYCLE_LO, then CYCLE_HI -> CYCLE_HI returns 0
//  5 Force cycle=0x0000_0000_FFFF_FFFF, read CYCLE_LO; after the wrap, CYCLE_HI still
//    returns 0 (shadow), not 1
//  6 SW 0x1 to 0x8000_0010 -> halt_o=1, tohost_o=1, held until resetn_i=0;
//    with macro off, the same store lands in RAM word 4 and halt_o stays 0

Source files
------------

// File: rtl/rv32i_dmem_responder.sv
// RV32I data-memory responder: byte-writable RAM with zero-latency reads.
// Optional MMIO block (cycle counter, timer compare, tohost) under RV32I_DMEM_MMIO_EN.
module rv32i_dmem_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [31:0] dmem_add_i,
  input  logic [31:0] dmem_di_i,
  input  logic [3:0]  dmem_ble_i,
  input  logic        dmem_we_i,
  output logic [31:0] dmem_do_o,
  output logic        timer_irq_o,
  output logic        halt_o,
  output logic [31:0] tohost_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [31:0]           ram_rdata;
  logic                  ram_we;
  logic                  unused_bits;

  assign ram_idx     = dmem_add_i[ADDR_WIDTH+1:2];
  assign ram_rdata   = mem_q[ram_idx];
  assign unused_bits = ^{dmem_add_i[31:ADDR_WIDTH+2], dmem_add_i[1:0]};

  // RAM is not reset; a store seen while reset is held is dropped
  always_ff @(posedge clk_i) begin
    if (resetn_i && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_ble_i[b]) begin
          mem_q[ram_idx][8*b +: 8] <= dmem_di_i[8*b +: 8];
        end
      end
    end
  end

`ifdef RV32I_DMEM_MMIO_EN

  localparam logic [28:0] W_CYC_LO = 29'd0;
  localparam logic [28:0] W_CYC_HI = 29'd1;
  localparam logic [28:0] W_TCM_LO = 29'd2;
  localparam logic [28:0] W_TCM_HI = 29'd3;
  localparam logic [28:0] W_TOHOST = 29'd4;

  function automatic logic [31:0] merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  ble
  );
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (ble[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  logic        mmio_sel;
  logic [28:0] woff;
  logic        sel_clo, sel_chi, sel_tlo, sel_thi, sel_toh;
  logic [31:0] mmio_rdata;

  logic [63:0] cycle_q, cycle_d;
  logic [63:0] tcmp_q, tcmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] tohost_q, tohost_d;
  logic        halt_q, halt_d;
  logic        irq_q, irq_d;

  assign mmio_sel = dmem_add_i[31];
  assign woff     = dmem_add_i[30:2];
  assign sel_clo  = mmio_sel && (woff == W_CYC_LO);
  assign sel_chi  = mmio_sel && (woff == W_CYC_HI);
  assign sel_tlo  = mmio_sel && (woff == W_TCM_LO);
  assign sel_thi  = mmio_sel && (woff == W_TCM_HI);
  assign sel_toh  = mmio_sel && (woff == W_TOHOST);
  assign ram_we   = dmem_we_i && !mmio_sel;

  always_comb begin
    cycle_d  = cycle_q + 64'd1;
    tcmp_d   = tcmp_q;
    shadow_d = shadow_q;
    tohost_d = tohost_q;
    halt_d   = halt_q;
    irq_d    = (cycle_q >= tcmp_q);
    // Loading CYCLE_LO snapshots the high half for a coherent CYCLE_HI read
    if (sel_clo && !dmem_we_i) shadow_d = cycle_q[63:32];
    if (dmem_we_i) begin
      if (sel_tlo) tcmp_d[31:0]  = merge(tcmp_q[31:0], dmem_di_i, dmem_ble_i);
      if (sel_thi) tcmp_d[63:32] = merge(tcmp_q[63:32], dmem_di_i, dmem_ble_i);
      if (sel_toh && |dmem_ble_i) begin
        tohost_d = merge(tohost_q, dmem_di_i, dmem_ble_i);
        halt_d   = 1'b1;
      end
    end
  end

  always_comb begin
    mmio_rdata = 32'd0;
    unique case (1'b1)
      sel_clo: mmio_rdata = cycle_q[31:0];
      sel_chi: mmio_rdata = shadow_q;
      sel_tlo: mmio_rdata = tcmp_q[31:0];
      sel_thi: mmio_rdata = tcmp_q[63:32];
      sel_toh: mmio_rdata = tohost_q;
      default: mmio_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cycle_q  <= 64'd0;
      tcmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_q <= 32'd0;
      tohost_q <= 32'd0;
      halt_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      tcmp_q   <= tcmp_d;
      shadow_q <= shadow_d;
      tohost_q <= tohost_d;
      halt_q   <= halt_d;
      irq_q    <= irq_d;
    end
  end

  assign dmem_do_o   = mmio_sel ? mmio_rdata : ram_rdata;
  assign timer_irq_o = irq_q;
  assign halt_o      = halt_q;
  assign tohost_o    = tohost_q;

`else

  assign ram_we      = dmem_we_i;
  assign dmem_do_o   = ram_rdata;
  assign timer_irq_o = 1'b0;
  assign halt_o      = 1'b0;
  assign tohost_o    = 32'd0;

`endif

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed bench for rv32i_dmem_responder: RAM vector table plus
// hand-written reset, timer, shadow and tohost sequences.
module tb_rv32i_dmem_responder;

  logic        clk;
  logic        resetn;
  logic [31:0] add;
  logic [31:0] di;
  logic [3:0]  ble;
  logic        we;
  logic [31:0] dout;
  logic        irq;
  logic        halt;
  logic [31:0] tohost;

  int checks;
  int failures;

  rv32i_dmem_responder #(.ADDR_WIDTH(10)) dut (
    .clk_i      (clk),
    .resetn_i   (resetn),
    .dmem_add_i (add),
    .dmem_di_i  (di),
    .dmem_ble_i (ble),
    .dmem_we_i  (we),
    .dmem_do_o  (dout),
    .timer_irq_o(irq),
    .halt_o     (halt),
    .tohost_o   (tohost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] add;
    logic [31:0] di;
    logic [3:0]  ble;
    logic        we;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [31:0] a, input logic [31:0] d,
    input logic [3:0] b, input logic w,
    input logic c, input logic [31:0] e, input string n
  );
    vec_t v;
    v.add = a; v.di = d; v.ble = b; v.we = w;
    v.chk = c; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs after a negedge; outputs settle by #1
  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic w);
    @(negedge clk);
    add = a; di = d; ble = b; we = w;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    add = '0; di = '0; ble = '0; we = 1'b0;

    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_tohost", tohost, 32'd0);

    repeat (2) @(negedge clk);
    resetn = 1'b1;

    tbl.push_back(mk(32'h10, 32'h1234_5678, 4'hF, 1, 0, 0, "sw_init"));
    tbl.push_back(mk(32'h10, 32'h0, 4'h0, 0, 1, 32'h1234_5678, "lw_word"));
    tbl.push_back(mk(32'h11, 32'h0000_AB00, 4'h2, 1, 1, 32'h1234_5678, "sb_old"));
    tbl.push_back(mk(32'h10, 32'h0, 4'h0, 0, 1, 32'h1234_AB78, "sb_merge"));
    tbl.push_back(mk(32'h10, 32'hFFFF_FFFF, 4'h0, 1, 1, 32'h1234_AB78, "ble0_rd"));
    tbl.push_back(mk(32'h13, 32'h0, 4'h0, 0, 1, 32'h1234_AB78, "ble0_keep"));
    tbl.push_back(mk(32'h20, 32'h0, 4'hF, 1, 0, 0, "w20_init"));
    tbl.push_back(mk(32'h20, 32'hDEAD_BEEF, 4'hF, 1, 1, 32'h0, "rw_old"));
    tbl.push_back(mk(32'h20, 32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF, "rw_new"));
    tbl.push_back(mk(32'h24, 32'h1122_3344, 4'hF, 1, 0, 0, "w24_init"));
    tbl.push_back(mk(32'h24, 32'hAABB_CCDD, 4'h9, 1, 1, 32'h1122_3344, "ble9_old"));
    tbl.push_back(mk(32'h24, 32'h0, 4'h0, 0, 1, 32'hAA22_33DD, "ble9_merge"));
    tbl.push_back(mk(32'hFFC, 32'hCAFE_F00D, 4'hF, 1, 0, 0, "wtop"));
    tbl.push_back(mk(32'hFFC, 32'h0, 4'h0, 0, 1, 32'hCAFE_F00D, "rtop"));
    tbl.push_back(mk(32'h1010, 32'h0, 4'h0, 0, 1, 32'h1234_AB78, "alias_hi"));
    tbl.push_back(mk(32'h10, 32'h0, 4'h0, 0, 1, 32'h1234_AB78, "no_corrupt"));
    tbl.push_back(mk(32'h30, 32'h0BAD_F00D, 4'hF, 1, 0, 0, "w30_init"));
    tbl.push_back(mk(32'h30, 32'h0, 4'h0, 0, 1, 32'h0BAD_F00D, "r30"));

    foreach (tbl[i]) begin
      drive(tbl[i].add, tbl[i].di, tbl[i].ble, tbl[i].we);
      if (tbl[i].chk) check(tbl[i].name, dout, tbl[i].exp);
    end

    // Store presented while reset is held must be dropped
    @(negedge clk);
    resetn = 1'b0;
    add = 32'h30; di = 32'hFFFF_FFFF; ble = 4'hF; we = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    we = 1'b0;
    #1;
    check("rst_drop", dout, 32'h0BAD_F00D);
    check("rst2_halt", {31'd0, halt}, 32'd0);

`ifdef RV32I_DMEM_MMIO_EN
    begin
      int  c;
      bit  done;
      drive(32'h8000_0004, 32'h0, 4'h0, 0);
      check("chi_rst", dout, 32'h0);
      drive(32'h8000_0008, 32'd20, 4'hF, 1);
      drive(32'h8000_000C, 32'd0, 4'hF, 1);
      drive(32'h8000_0008, 32'd0, 4'h0, 0);
      check("tcmp_lo", dout, 32'd20);
      done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
        drive(32'h8000_0000, 32'h0, 4'h0, 0);
        c = int'(dout);
        check($sformatf("irq_c%0d", c), {31'd0, irq},
              {31'd0, (c >= 21)});
        if (c >= 24) done = 1;
      end
      if (!done) check("t4_timeout", 32'd0, 32'd1);
      drive(32'h8000_0004, 32'h0, 4'h0, 0);
      check("chi_zero", dout, 32'h0);

      @(negedge clk);
      force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
      add = 32'h8000_0000; di = '0; ble = '0; we = 1'b0;
      #1;
      check("clo_max", dout, 32'hFFFF_FFFF);
      release dut.cycle_q;
      drive(32'h8000_0004, 32'h0, 4'h0, 0);
      check("shadow_wrap", dout, 32'h0);
      drive(32'h8000_0000, 32'h0, 4'h0, 0);
      check("clo_after", dout, 32'h1);
      drive(32'h8000_0004, 32'h0, 4'h0, 0);
      check("chi_after", dout, 32'h1);

      drive(32'h8000_0010, 32'h1, 4'h0, 1);
      drive(32'h8000_0010, 32'h1, 4'hF, 1);
      check("halt_late", {31'd0, halt}, 32'd0);
      for (int k = 0; k < 3; k++) begin
        drive(32'h0, 32'h0, 4'h0, 0);
        check("halt_set", {31'd0, halt}, 32'd1);
        check("tohost_val", tohost, 32'h1);
      end
      drive(32'h10, 32'h0, 4'h0, 0);
      check("ram_untouched", dout, 32'h1234_AB78);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("halt_clr", {31'd0, halt}, 32'd0);
      check("tohost_clr", tohost, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
    end
`else
    drive(32'h8000_0010, 32'h1, 4'hF, 1);
    drive(32'h10, 32'h0, 4'h0, 0);
    check("th_ram", dout, 32'h1);
    check("th_halt", {31'd0, halt}, 32'd0);
    check("th_tohost", tohost, 32'd0);
    drive(32'h8000_0010, 32'h0, 4'h0, 0);
    check("th_alias", dout, 32'h1);
    check("th_irq", {31'd0, irq}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
